// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: default vectors, exception
// codes, FSM encoding and small address helpers reused by the M-stage checker.
package pc_fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_DEF    = 32'h0000_6ffc;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_EXC  = 3'd0,
        SEL_ERET = 3'd1,
        SEL_HOLD = 3'd2,
        SEL_NPC  = 3'd3,
        SEL_SEQ  = 3'd4
    } pc_sel_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic word_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_addr_chk.sv
// Combinational word-address checker raising AdEL on misalignment and, when
// PC_RANGE_CHECK_EN is defined, on addresses outside [ADDR_LO, ADDR_HI].
module pc_addr_chk
    import pc_fetch_ctrl_pkg::*;
#(
`ifdef PC_RANGE_CHECK_EN
    parameter logic [31:0] ADDR_LO = IMEM_LO_DEF,
    parameter logic [31:0] ADDR_HI = IMEM_HI_DEF
`endif
) (
    input  logic [31:0] addr,
    input  logic        addr_valid,
    output logic        adel
);

    logic out_of_range_s;

`ifdef PC_RANGE_CHECK_EN
    // Window compare against the legal instruction-memory range.
    always_comb begin
        out_of_range_s = (addr < ADDR_LO) || (addr > ADDR_HI);
    end
`else
    // Without the window check only alignment matters.
    always_comb begin
        out_of_range_s = 1'b0;
    end
`endif

    // A bubble never raises an address error.
    always_comb begin
        if (addr_valid) begin
            adel = word_misaligned(addr) | out_of_range_s;
        end else begin
            adel = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC register and next-PC selection for the 5-stage MIPS pipeline.
// Optional macro PC_RANGE_CHECK_EN adds the IMEM_LO/IMEM_HI window to the AdEL check.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`ifdef PC_RANGE_CHECK_EN
    ,
    parameter logic [31:0] IMEM_LO    = IMEM_LO_DEF,
    parameter logic [31:0] IMEM_HI    = IMEM_HI_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_change,
    input  logic [31:0] npc_target,
    input  logic        is_jump_d,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        fetch_valid,
    output logic        bd_f,
    output logic        adel_f,
    output logic [4:0]  exccode_f,
    output logic        flush_fd
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    pc_sel_e      pc_sel_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic         bd_r;
    logic         bd_nxt_s;
    logic         fv_r;
    logic         fv_nxt_s;

    // Source priority: CP0 redirects beat the hazard freeze, which beats D-stage redirects.
    always_comb begin
        pc_sel_s = SEL_SEQ;
        if (exc_req) begin
            pc_sel_s = SEL_EXC;
        end else if (eret_req) begin
            pc_sel_s = SEL_ERET;
        end else if (stall) begin
            pc_sel_s = SEL_HOLD;
        end else if (npc_change) begin
            pc_sel_s = SEL_NPC;
        end else begin
            pc_sel_s = SEL_SEQ;
        end
    end

    // Next PC, FSM state, delay-slot flag and valid flag for the selected source.
    always_comb begin
        pc_nxt_s    = pc_plus4(pc_r);
        state_nxt_s = RUN;
        bd_nxt_s    = 1'b0;
        fv_nxt_s    = 1'b1;
        case (pc_sel_s)
            SEL_EXC: begin
                pc_nxt_s    = EXC_VECTOR;
                state_nxt_s = REDIR;
                fv_nxt_s    = ~stall;
            end
            SEL_ERET: begin
                pc_nxt_s    = epc;
                state_nxt_s = REDIR;
                fv_nxt_s    = ~stall;
            end
            SEL_HOLD: begin
                pc_nxt_s = pc_r;
                bd_nxt_s = bd_r;
            end
            SEL_NPC: begin
                pc_nxt_s = npc_target;
                bd_nxt_s = is_jump_d;
            end
            SEL_SEQ: begin
                bd_nxt_s = is_jump_d;
            end
            default: begin
                pc_nxt_s = RESET_PC;
            end
        endcase
    end

    // Fetch registers; reset is sampled here so it overrides every other source.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            state_r <= RUN;
            bd_r    <= 1'b0;
            fv_r    <= 1'b1;
        end else begin
            pc_r    <= pc_nxt_s;
            state_r <= state_nxt_s;
            bd_r    <= bd_nxt_s;
            fv_r    <= fv_nxt_s;
        end
    end

    // The instruction after a taken branch is still executed, so only CP0 redirects flush.
    assign flush_fd    = ~reset & (exc_req | eret_req);
    assign pc_f        = pc_r;
    assign pc4_f       = pc_plus4(pc_r);
    assign fetch_valid = fv_r;
    assign bd_f        = bd_r & (state_r == RUN);

    pc_addr_chk #(
`ifdef PC_RANGE_CHECK_EN
        .ADDR_LO (IMEM_LO),
        .ADDR_HI (IMEM_HI)
`endif
    ) u_addr_chk (
        .addr       (pc_r),
        .addr_valid (fv_r),
        .adel       (adel_f)
    );

    // Exception code follows the address-error flag.
    always_comb begin
        if (adel_f) begin
            exccode_f = EXC_ADEL;
        end else begin
            exccode_f = EXC_NONE;
        end
    end

endmodule
